// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared types and helpers for the nibble-serial CLA adder.
// Holds the FSM state enum, the nibble width and the index-width helper.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Bits needed to count n nibbles; never less than one.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder.
// Ports: a, b (4b), cin in; s (4b), c4 out.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is flattened from g/p so no ripple path exists.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0])
            | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: accepts a/b/cin over valid/ready, adds one nibble
// per clock through cla4_slice, and presents sum/cout over valid/ready.
// Ports: clk, reset (async, active low), in_valid/in_ready, a, b, cin,
// out_valid/out_ready, sum, cout, busy.
// Define CLA_SEQ_SUBTRACT_EN to add a sub input selecting a-b.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c4;

  assign a_nib = a_reg[{idx, 2'b00} +: NIBBLE_W];
  assign b_nib = b_reg[{idx, 2'b00} +: NIBBLE_W];

  cla4_slice u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry),
    .s   (s_nib),
    .c4  (c4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
`ifdef CLA_SEQ_SUBTRACT_EN
            // a-b as a + ~b + 1; cout then means no borrow.
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_reg <= b;
            carry <= cin;
`endif
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: NIBBLE_W] <= s_nib;
          carry <= c4;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= c4;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
